// File: rtl/rf_debug_access.sv
// Debug-side initiator for the GPR file: halts the core, takes the register-file port for one cycle, and answers on a response channel.
// Optional RF_DEBUG_RV32E_EN limits indices to x0-x15 and rejects higher ones without halting.
module rf_debug_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned XLEN           = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [4:0]      cmd_regno,
    input  logic [XLEN-1:0] cmd_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            halt_req,
    input  logic            halted,
    output logic            rf_sel,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_w_data,
    output logic            rf_wen,
    input  logic [XLEN-1:0] rf_rs1_data
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef RF_DEBUG_RV32E_EN
    localparam logic RV32E = 1'b1;
`else
    localparam logic RV32E = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT_HALT, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lat_write_q, lat_write_d;
    logic [4:0]        lat_regno_q, lat_regno_d;
    logic [XLEN-1:0]   lat_wdata_q, lat_wdata_d;

    logic              cmd_ready_d, rsp_valid_d, rsp_err_d, halt_req_d;
    logic [XLEN-1:0]   rsp_rdata_d, rf_w_data_d;
    logic              rf_sel_d, rf_wen_d;
    logic [4:0]        rf_idx_d;
    logic              cmd_illegal;
    logic              in_access_d;

    assign cmd_illegal = RV32E & cmd_regno[4];

    // Next-state, latched command, response data, and next registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_write_d = lat_write_q;
        lat_regno_d = lat_regno_q;
        lat_wdata_d = lat_wdata_q;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    lat_write_d = cmd_write;
                    lat_regno_d = cmd_regno;
                    lat_wdata_d = cmd_wdata;
                    if (cmd_illegal) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = WAIT_HALT;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT_HALT: begin
                // halted takes priority over an expiring timeout
                if (halted) begin
                    state_d = ACCESS;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d     = RESP;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACCESS: begin
                state_d     = RESP;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = lat_write_q ? '0 : rf_rs1_data;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        in_access_d = (state_d == ACCESS);
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        halt_req_d  = (state_d == WAIT_HALT) || in_access_d;
        rf_sel_d    = in_access_d;
        rf_idx_d    = in_access_d ? {lat_regno_d[4] & ~RV32E, lat_regno_d[3:0]} : 5'd0;
        rf_wen_d    = in_access_d && lat_write_d && (lat_regno_d != 5'd0);
        rf_w_data_d = (in_access_d && lat_write_d) ? lat_wdata_d : '0;
    end

    // Async reset drops the register-file takeover immediately
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lat_write_q <= 1'b0;
            lat_regno_q <= 5'd0;
            lat_wdata_q <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            halt_req    <= 1'b0;
            rf_sel      <= 1'b0;
            rf_rs1      <= 5'd0;
            rf_rd       <= 5'd0;
            rf_w_data   <= '0;
            rf_wen      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_write_q <= lat_write_d;
            lat_regno_q <= lat_regno_d;
            lat_wdata_q <= lat_wdata_d;
            cmd_ready   <= cmd_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            halt_req    <= halt_req_d;
            rf_sel      <= rf_sel_d;
            rf_rs1      <= rf_idx_d;
            rf_rd       <= rf_idx_d;
            rf_w_data   <= rf_w_data_d;
            rf_wen      <= rf_wen_d;
        end
    end

endmodule

// File: tb/tb_rf_debug_access.sv
// Self-checking bench for rf_debug_access: vector table of debug commands against a simple register-file model.
module tb_rf_debug_access;

    localparam int unsigned XLEN = 32;

    logic            CLK;
    logic            nRST;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [4:0]      cmd_regno;
    logic [XLEN-1:0] cmd_wdata;
    logic            rsp_valid, rsp_ready, rsp_err;
    logic [XLEN-1:0] rsp_rdata;
    logic            halt_req, halted;
    logic            rf_sel, rf_wen;
    logic [4:0]      rf_rs1, rf_rd;
    logic [XLEN-1:0] rf_w_data, rf_rs1_data;

    int tests;
    int fails;

    rf_debug_access #(.TIMEOUT_CYCLES(8), .XLEN(XLEN)) dut (
        .CLK(CLK), .nRST(nRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_regno(cmd_regno), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .halt_req(halt_req), .halted(halted),
        .rf_sel(rf_sel), .rf_rs1(rf_rs1), .rf_rd(rf_rd), .rf_w_data(rf_w_data),
        .rf_wen(rf_wen), .rf_rs1_data(rf_rs1_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register-file model; reloads known contents on reset
    logic [31:0] rf_mem [32];

    function automatic logic [31:0] preset(input int i);
        return (i == 5) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(i));
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= preset(i);
        end else if (rf_wen && rf_rd != 5'd0) begin
            rf_mem[rf_rd] <= rf_w_data;
        end
    end

    assign rf_rs1_data = (rf_rs1 == 5'd0) ? 32'd0 : rf_mem[rf_rs1];

    typedef struct {
        bit          write;
        logic [4:0]  regno;
        logic [31:0] wdata;
        int          hdly;   // cycles after halt_req before halted rises
        int          hold;   // cycles rsp_ready held low in RESP
        int          lat;
        logic [31:0] rdata;
        bit          err;
        int          sel;
        int          wen;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int k = 0;
        int sel_n = 0;
        int wen_n = 0;
        logic [4:0] wrd = 5'd0;
        logic [31:0] wdat = 32'd0;
        bit got = 0;
        bit hseen = 0;
        string tag;
        tag = $sformatf("v%0d", idx);

        @(negedge CLK);
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_regno = v.regno;
        cmd_wdata = v.wdata;
        halted    = (v.hdly == 0);
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        cmd_wdata = 32'd0;

        while (!got && k < 40) begin
            @(negedge CLK);
            k++;
            if (rf_sel) sel_n++;
            if (rf_wen) begin
                wen_n++;
                wrd  = rf_rd;
                wdat = rf_w_data;
            end
            if (halt_req) hseen = 1;
            if (rsp_valid) got = 1;
            halted = (k >= 1 + v.hdly);
        end

        chk({tag, " latency"}, 32'(k), 32'(v.lat));
        chk({tag, " rsp_rdata"}, rsp_rdata, v.rdata);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(v.err));
        chk({tag, " halt_req in RESP"}, 32'(halt_req), 32'd0);
        chk({tag, " rf_sel cycles"}, 32'(sel_n), 32'(v.sel));
        chk({tag, " rf_wen cycles"}, 32'(wen_n), 32'(v.wen));
        chk({tag, " halt_req seen"}, 32'(hseen), 32'(v.lat != 1));
        if (v.wen != 0) begin
            chk({tag, " rf_rd"}, 32'(wrd), 32'(v.regno));
            chk({tag, " rf_w_data"}, wdat, v.wdata);
        end

        for (int h = 0; h < v.hold; h++) begin
            rsp_ready = 1'b0;
            @(negedge CLK);
            chk({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold rsp_rdata"}, rsp_rdata, v.rdata);
        end

        rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        rsp_ready = 1'b0;
        @(negedge CLK);
        chk({tag, " post cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " post rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, " post rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        tests = 0;
        fails = 0;
        nRST = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_regno = 5'd0;
        cmd_wdata = 32'd0;
        rsp_ready = 1'b0;
        halted    = 1'b0;

        //          write regno  wdata          hdly hold lat rdata          err sel wen
        vecs[0] = '{1'b0, 5'd5,  32'd0,         0,   5,   3,  32'hDEAD_BEEF, 1'b0, 1, 0};
        vecs[1] = '{1'b1, 5'd7,  32'h1234_5678, 4,   0,   7,  32'd0,         1'b0, 1, 1};
        vecs[2] = '{1'b0, 5'd7,  32'd0,         0,   0,   3,  32'h1234_5678, 1'b0, 1, 0};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 0,   0,   3,  32'd0,         1'b0, 1, 0};
        vecs[4] = '{1'b0, 5'd0,  32'd0,         0,   0,   3,  32'd0,         1'b0, 1, 0};
        vecs[5] = '{1'b0, 5'd3,  32'd0,         999, 0,   10, 32'd0,         1'b1, 0, 0};
`ifdef RF_DEBUG_RV32E_EN
        vecs[6] = '{1'b0, 5'd20, 32'd0,         0,   0,   1,  32'd0,         1'b1, 0, 0};
`else
        vecs[6] = '{1'b0, 5'd20, 32'd0,         0,   0,   3,  32'hA5A5_0014, 1'b0, 1, 0};
`endif
        vecs[7] = '{1'b1, 5'd12, 32'hCAFE_F00D, 1,   0,   4,  32'd0,         1'b0, 1, 1};
        vecs[8] = '{1'b0, 5'd12, 32'd0,         0,   2,   3,  32'hCAFE_F00D, 1'b0, 1, 0};

        repeat (3) @(negedge CLK);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset halt_req", 32'(halt_req), 32'd0);
        chk("reset rf_sel", 32'(rf_sel), 32'd0);
        chk("reset rf_wen", 32'(rf_wen), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        nRST = 1'b1;
        @(negedge CLK);
        chk("after reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("after reset rf_rs1", 32'(rf_rs1), 32'd0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset pulsed in the middle of a write access
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_regno = 5'd9;
        cmd_wdata = 32'h0000_0055;
        halted    = 1'b1;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("mid access rf_sel", 32'(rf_sel), 32'd1);
        chk("mid access rf_wen", 32'(rf_wen), 32'd1);
        chk("mid access rf_rd", 32'(rf_rd), 32'd9);
        #1;
        nRST = 1'b0;
        #1;
        chk("async reset rf_wen", 32'(rf_wen), 32'd0);
        chk("async reset rf_sel", 32'(rf_sel), 32'd0);
        chk("async reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async reset halt_req", 32'(halt_req), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        chk("release cmd_ready", 32'(cmd_ready), 32'd1);
        chk("release rsp_valid", 32'(rsp_valid), 32'd0);
        chk("release rf_sel", 32'(rf_sel), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_debug_access.md
# rf_debug_access

Debug-side initiator for the GPR file. The block accepts abstract register read/write commands from the debug module, halts the core, and drives the register-file port for one cycle through a takeover mux. It then returns data or an error on a response channel. It sits beside the register-file wrapper and is the requesting end of the same `rf_if` signal set that the pipeline normally drives.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum number of cycles spent in WAIT_HALT before the command is aborted with an error; must be ≥1.
- `XLEN`, 32: register data width.

Ports:
- `CLK`  in  1  clock; rising edge.
- `nRST`  in  1  reset; asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_regno`  in  5  GPR index.
- `cmd_wdata`  in  XLEN  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  XLEN  read data; 0 for writes and errors.
- `rsp_err`  out  1  command failed.
- `halt_req`  out  1  request core halt.
- `halted`  in  1  core is quiescent; the register-file port may be taken.
- `rf_sel`  out  1  1 = mux passes this block's signals to the register file.
- `rf_rs1`  out  5  read index.
- `rf_rd`  out  5  write index.
- `rf_w_data`  out  XLEN  write data.
- `rf_wen`  out  1  write enable.
- `rf_rs1_data`  in  XLEN  combinational read data for `rf_rs1`.

## Operation
- Four states: IDLE, WAIT_HALT, ACCESS, RESP. All outputs are registered or Moore-decoded from state.
- **IDLE**
  - `cmd_ready`=1. On `cmd_valid`&`cmd_ready`, latch `cmd_write`, `cmd_regno` and `cmd_wdata`.
  - If the index is illegal (see Configuration), go to RESP with err=1.
  - Otherwise go to WAIT_HALT and clear the timeout counter.
- **WAIT_HALT**
  - `halt_req`=1. The counter increments each cycle.
  - If `halted` is sampled 1, go to ACCESS.
  - Otherwise, if the counter reaches `TIMEOUT_CYCLES`, go to RESP with err=1.
  - If `halted` arrives on the timeout cycle, `halted` wins.
- **ACCESS** (exactly 1 cycle)
  - `halt_req`=1, `rf_sel`=1, `rf_rs1`=`rf_rd`=latched index.
  - Write: `rf_w_data`=latched data; `rf_wen`=1 unless the index is 0. A write to x0 drives `rf_wen`=0 and completes with err=0.
  - Read: `rf_rs1_data` is captured into `rsp_rdata` at the cycle-ending edge.
  - Go to RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_rdata` and `rsp_err` are held stable.
  - `halt_req`=0 and `rf_sel`=0.
  - On `rsp_ready`, go to IDLE. `rsp_rdata` and `rsp_err` clear to 0 on that transition.
- `cmd_ready` is 0 in every state except IDLE, so at most one command is outstanding.
- When not in ACCESS, `rf_rs1`, `rf_rd`, `rf_w_data` and `rf_wen` are 0.
- If `halted` drops during ACCESS, the access still completes. Safety of the halt is the core's responsibility.

## Timing
- Reset (async, any state): state=IDLE, counter=0. Every output is 0 except `cmd_ready`, which is 1 once out of reset.
- Command handshake at cycle t, with `halted` already 1:
  - t+1: WAIT_HALT, `halt_req`=1.
  - t+2: ACCESS.
  - t+3: `rsp_valid`=1.
  - Minimum latency is 3 cycles.
- Error on index: `rsp_valid`=1 at t+1; `halt_req` is never asserted.
- Timeout: `rsp_valid`=1, err=1 at cycle t+1+`TIMEOUT_CYCLES`+1 if `halted` stays 0.
- Response handshake at cycle r: `cmd_ready`=1 at r+1. A new command may be accepted at r+1.
- Reset asserted mid-ACCESS: `rf_wen` and `rf_sel` drop immediately (asynchronously). A partial write is not retried.

## Configuration
- `RF_DEBUG_RV32E_EN` defined:
  - The target is an RV32E register file (x0–x15). Any `cmd_regno`≥16 is illegal and is answered with err=1 at t+1, with no halt.
  - `rf_rs1` and `rf_rd` bit 4 is driven 0.
- Macro undefined: all 32 indices are legal, and no index error exists.

## Test plan
- Read x5 (file holds 0xDEADBEEF), `halted` tied 1 → `rsp_valid` at t+3, `rsp_rdata`=0xDEADBEEF, err=0; `rf_sel` high exactly 1 cycle.
- Write x7=0x12345678, `halted` asserted 4 cycles after `halt_req` → one `rf_wen` pulse with `rf_rd`=7, `rf_w_data`=0x12345678; a following read of x7 returns 0x12345678, err=0.
- Write x0=0xFFFFFFFF → `rf_wen` never asserts, err=0; a read of x0 returns 0.
- `TIMEOUT_CYCLES`=8, `halted` held 0 → err=1 at t+10, `rsp_rdata`=0, `rf_sel` never asserted, `halt_req` low in RESP.
- With `RF_DEBUG_RV32E_EN`: read x20 → err=1 at t+1, `halt_req` stays 0. Without the macro: the same read succeeds.
- `nRST` pulsed low during ACCESS of a write → `rf_wen` and `rf_sel` go 0 asynchronously, `rsp_valid`=0, `cmd_ready`=1 after release. Hold `rsp_ready`=0 for 5 cycles in a normal read → `rsp_rdata` is stable throughout.
